pipelined_alu: RTL and testbench

PIPELINED_ALU -- requirements
Module: pipelined_alu

---
 rtl/pipelined_alu.sv | 155 +++++++++++++++
 tb/tb_pipelined_alu.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_alu.sv
// Two-stage ALU: operand latch (S1), then compute into result/flags register (S2).
// Latency: an op accepted at an edge is on out_valid after the following edge.
// Backpressure: the stages shift forward only when downstream has room, so in_ready drops when both are full.
//
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   in_valid / in_ready       operation handshake (data_one, data_two, shift, control)
//   out_valid / out_ready     result handshake (result, flags = {Z, V, N})
//   busy                      high while either stage holds a valid entry
module pipelined_alu #(
    parameter int  WIDTH = 16,
    parameter bit  SAT   = 1'b0,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_one,
    input  logic [WIDTH-1:0] data_two,
    input  logic [SHW-1:0]   shift,
    input  logic [2:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags,
    output logic             busy
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_INC  = 3'b100;
    localparam logic [2:0] OP_SRA  = 3'b101;
    localparam logic [2:0] OP_SRL  = 3'b110;
    localparam logic [2:0] OP_SLL  = 3'b111;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // S1: operand/opcode latch
    logic             r_s1_vld;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [SHW-1:0]   r_s1_sh;
    logic [2:0]       r_s1_op;

    // S2: result/flags register
    logic             r_s2_vld;
    logic [WIDTH-1:0] r_result;
    logic [2:0]       r_flags;

    logic             w_s1_load;
    logic             w_s2_load;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_v_add;
    logic             w_v_sub;
    logic [WIDTH-1:0] w_res;
    logic             w_v;
    logic             w_is_shift;
    logic [2:0]       w_flags;

    assign w_s2_load = !r_s2_vld || out_ready;
    assign w_s1_load = !r_s1_vld || w_s2_load;

    assign in_ready  = w_s1_load;
    assign out_valid = r_s2_vld;
    assign result    = r_result;
    assign flags     = r_flags;
    assign busy      = r_s1_vld || r_s2_vld;

    // INC shares the adder with B forced to one.
    assign w_addend = (r_s1_op == OP_INC) ? {{(WIDTH-1){1'b0}}, 1'b1} : r_s1_b;
    assign w_sum    = {1'b0, r_s1_a} + {1'b0, w_addend};
    assign w_diff   = r_s1_a - r_s1_b;

    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    assign w_v_add = w_sum[WIDTH] ^ (w_sum[WIDTH-1] ^ r_s1_a[WIDTH-1] ^ w_addend[WIDTH-1]);
    assign w_v_sub = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_s1_a[WIDTH-1]);

    assign w_is_shift = (r_s1_op == OP_SRA) || (r_s1_op == OP_SRL) || (r_s1_op == OP_SLL);

    always_comb begin
        w_res   = '0;
        w_v     = 1'b0;
        w_flags = 3'b000;
        case (r_s1_op)
            OP_ADD, OP_INC: begin
                w_res = w_sum[WIDTH-1:0];
                w_v   = w_v_add;
            end
            OP_SUB: begin
                w_res = w_diff;
                w_v   = w_v_sub;
            end
            OP_NAND: w_res = ~(r_s1_a & r_s1_b);
            OP_XOR:  w_res = r_s1_a ^ r_s1_b;
            OP_SRA:  w_res = $signed(r_s1_a) >>> r_s1_sh;
            OP_SRL:  w_res = r_s1_a >> r_s1_sh;
            OP_SLL:  w_res = r_s1_a << r_s1_sh;
            default: w_res = '0;
        endcase

        // Every overflow case (ADD/SUB/INC) has its direction given by A's sign:
        // a positive A can only overflow upward, a negative A only downward.
        if (SAT && w_v) begin
            w_res = r_s1_a[WIDTH-1] ? MIN_NEG : MAX_POS;
        end

        if (r_s1_op == OP_NAND || r_s1_op == OP_XOR) begin
            w_flags = {(w_res == '0), 1'b0, 1'b0};
        end else begin
            w_flags = {(w_res == '0), w_v, w_res[WIDTH-1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_sh  <= '0;
            r_s1_op  <= 3'b000;
        end else if (w_s1_load) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_a  <= data_one;
                r_s1_b  <= data_two;
                r_s1_sh <= shift;
                r_s1_op <= control;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_vld <= 1'b0;
            r_result <= '0;
            r_flags  <= 3'b000;
        end else if (w_s2_load) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_result <= w_res;
                // Shifts keep the flags of the last completed non-shift op.
                if (!w_is_shift) begin
                    r_flags <= w_flags;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_alu.sv
module tb_pipelined_alu;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, NAND = 3'b010, XOR = 3'b011;
    localparam logic [2:0] INC = 3'b100, SRA = 3'b101, SRL = 3'b110, SLL = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // 16-bit stimulus shared by the wrap-around and saturating instances
    logic        in_valid16 = 1'b0;
    logic        out_ready16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [3:0]  sh16 = '0;
    logic [2:0]  op16 = '0;

    logic        w_in_ready16, w_out_valid16, w_busy16;
    logic [15:0] w_result16;
    logic [2:0]  w_flags16;

    logic        s_in_ready16, s_out_valid16, s_busy16;
    logic [15:0] s_result16;
    logic [2:0]  s_flags16;

    // 32-bit instance
    logic        in_valid32 = 1'b0;
    logic        out_ready32 = 1'b1;
    logic [31:0] a32 = '0, b32 = '0;
    logic [4:0]  sh32 = '0;
    logic [2:0]  op32 = '0;

    logic        w_in_ready32, w_out_valid32, w_busy32;
    logic [31:0] w_result32;
    logic [2:0]  w_flags32;

    pipelined_alu #(.WIDTH(16), .SAT(1'b0)) u_alu16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(w_in_ready16),
        .data_one(a16), .data_two(b16), .shift(sh16), .control(op16),
        .out_valid(w_out_valid16), .out_ready(out_ready16),
        .result(w_result16), .flags(w_flags16), .busy(w_busy16)
    );

    pipelined_alu #(.WIDTH(16), .SAT(1'b1)) u_alu16_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(s_in_ready16),
        .data_one(a16), .data_two(b16), .shift(sh16), .control(op16),
        .out_valid(s_out_valid16), .out_ready(out_ready16),
        .result(s_result16), .flags(s_flags16), .busy(s_busy16)
    );

    pipelined_alu #(.WIDTH(32), .SAT(1'b0)) u_alu32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(w_in_ready32),
        .data_one(a32), .data_two(b32), .shift(sh32), .control(op32),
        .out_valid(w_out_valid32), .out_ready(out_ready32),
        .result(w_result32), .flags(w_flags32), .busy(w_busy32)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one 16-bit op for exactly one edge.
    task automatic issue16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] sh);
        op16 = op; a16 = a; b16 = b; sh16 = sh; in_valid16 = 1'b1;
        step();
        in_valid16 = 1'b0;
    endtask

    // Independent 32-bit reference: wide signed arithmetic with range test for V.
    logic [2:0] m_flags32 = 3'b000;

    task automatic model32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, output logic [31:0] r);
        longint sa, sb, s;
        logic v;
        sa = $signed(a);
        sb = $signed(b);
        s  = 0;
        v  = 1'b0;
        r  = '0;
        case (op)
            ADD, SUB, INC: begin
                if (op == ADD)      s = sa + sb;
                else if (op == SUB) s = sa - sb;
                else                s = sa + 1;
                r = s[31:0];
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                m_flags32 = {(r == 32'd0), v, r[31]};
            end
            NAND: begin
                r = ~(a & b);
                m_flags32 = {(r == 32'd0), 2'b00};
            end
            XOR: begin
                r = a ^ b;
                m_flags32 = {(r == 32'd0), 2'b00};
            end
            SRA: begin
                s = sa >>> sh;
                r = s[31:0];
            end
            SRL:     r = a >> sh;
            default: r = a << sh;
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++; if (w_out_valid16 !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%b want=0", w_out_valid16); end
        checks++; if (w_result16 !== 16'h0000) begin errs++; $display("FAIL reset_result got=%h want=0000", w_result16); end
        checks++; if (w_flags16 !== 3'b000) begin errs++; $display("FAIL reset_flags got=%b want=000", w_flags16); end
        checks++; if (w_busy16 !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b want=0", w_busy16); end
        checks++; if (w_out_valid32 !== 1'b0 || w_busy32 !== 1'b0) begin errs++; $display("FAIL reset_32 valid=%b busy=%b want=0,0", w_out_valid32, w_busy32); end
        rst = 1'b0;
        #1;
        checks++; if (w_in_ready16 !== 1'b1) begin errs++; $display("FAIL reset_in_ready got=%b want=1", w_in_ready16); end
    endtask

    task automatic test_add_overflow();
        out_ready16 = 1'b1;
        op16 = ADD; a16 = 16'h7FFF; b16 = 16'h0001; sh16 = '0; in_valid16 = 1'b1;
        #1;
        checks++; if (w_in_ready16 !== 1'b1) begin errs++; $display("FAIL add_accept in_ready got=%b want=1", w_in_ready16); end
        step();
        in_valid16 = 1'b0;
        checks++; if (w_out_valid16 !== 1'b0 || w_busy16 !== 1'b1) begin errs++; $display("FAIL add_latency1 valid=%b busy=%b want=0,1", w_out_valid16, w_busy16); end
        step();
        checks++; if (w_out_valid16 !== 1'b1) begin errs++; $display("FAIL add_latency2 valid got=%b want=1", w_out_valid16); end
        checks++; if (w_result16 !== 16'h8000 || w_flags16 !== 3'b011) begin errs++; $display("FAIL add_wrap got=%h/%b want=8000/011", w_result16, w_flags16); end
        checks++; if (s_result16 !== 16'h7FFF || s_flags16 !== 3'b010) begin errs++; $display("FAIL add_sat got=%h/%b want=7fff/010", s_result16, s_flags16); end
        step();
        checks++; if (w_out_valid16 !== 1'b0 || w_busy16 !== 1'b0) begin errs++; $display("FAIL add_drain valid=%b busy=%b want=0,0", w_out_valid16, w_busy16); end
    endtask

    task automatic test_sub_saturate();
        issue16(SUB, 16'h8000, 16'h0001, 4'd0);
        step();
        checks++; if (s_result16 !== 16'h8000 || s_flags16 !== 3'b011) begin errs++; $display("FAIL sub_sat got=%h/%b want=8000/011", s_result16, s_flags16); end
        checks++; if (w_result16 !== 16'h7FFF || w_flags16 !== 3'b010) begin errs++; $display("FAIL sub_wrap got=%h/%b want=7fff/010", w_result16, w_flags16); end
    endtask

    task automatic test_flags_shift();
        issue16(SUB, 16'h1234, 16'h1234, 4'd0);
        step();
        checks++; if (w_result16 !== 16'h0000 || w_flags16 !== 3'b100) begin errs++; $display("FAIL sub_zero got=%h/%b want=0000/100", w_result16, w_flags16); end
        issue16(SRA, 16'h8000, 16'h0000, 4'd15);
        step();
        checks++; if (w_result16 !== 16'hFFFF || w_flags16 !== 3'b100) begin errs++; $display("FAIL sra15 got=%h/%b want=ffff/100", w_result16, w_flags16); end
        issue16(INC, 16'h7FFF, 16'h0000, 4'd0);
        step();
        checks++; if (w_result16 !== 16'h8000 || w_flags16 !== 3'b011) begin errs++; $display("FAIL inc_ovf got=%h/%b want=8000/011", w_result16, w_flags16); end
        checks++; if (s_result16 !== 16'h7FFF || s_flags16 !== 3'b010) begin errs++; $display("FAIL inc_sat got=%h/%b want=7fff/010", s_result16, s_flags16); end
        issue16(SRL, 16'h8000, 16'h0000, 4'd3);
        step();
        checks++; if (w_result16 !== 16'h1000 || w_flags16 !== 3'b011) begin errs++; $display("FAIL srl3 got=%h/%b want=1000/011", w_result16, w_flags16); end
        issue16(SLL, 16'h0003, 16'h0000, 4'd4);
        step();
        checks++; if (w_result16 !== 16'h0030) begin errs++; $display("FAIL sll4 got=%h want=0030", w_result16); end
        issue16(SRA, 16'hA5A5, 16'h0000, 4'd0);
        step();
        checks++; if (w_result16 !== 16'hA5A5) begin errs++; $display("FAIL sra0 got=%h want=a5a5", w_result16); end
        issue16(NAND, 16'h0F0F, 16'h00FF, 4'd0);
        step();
        checks++; if (w_result16 !== 16'hFFF0 || w_flags16 !== 3'b000) begin errs++; $display("FAIL nand got=%h/%b want=fff0/000", w_result16, w_flags16); end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready16 = 1'b0;
        op16 = XOR; a16 = 16'h00FF; b16 = 16'h0F0F; sh16 = '0; in_valid16 = 1'b1;
        #1;
        checks++; if (w_in_ready16 !== 1'b1) begin errs++; $display("FAIL b2b_accept1 in_ready got=%b want=1", w_in_ready16); end
        step();
        op16 = NAND; a16 = 16'hFFFF; b16 = 16'hFFFF;
        #1;
        checks++; if (w_in_ready16 !== 1'b1) begin errs++; $display("FAIL b2b_accept2 in_ready got=%b want=1", w_in_ready16); end
        step();
        op16 = ADD; a16 = 16'h0001; b16 = 16'h0002;
        #1;
        checks++; if (w_in_ready16 !== 1'b0) begin errs++; $display("FAIL b2b_full in_ready got=%b want=0", w_in_ready16); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (w_out_valid16 !== 1'b1 || w_result16 !== 16'h0FF0 || w_flags16 !== 3'b000 || w_in_ready16 !== 1'b0)
                begin errs++; $display("FAIL b2b_hold%0d valid=%b res=%h flags=%b rdy=%b want=1/0ff0/000/0", i, w_out_valid16, w_result16, w_flags16, w_in_ready16); end
        end
        out_ready16 = 1'b1;
        #1;
        checks++; if (w_in_ready16 !== 1'b1) begin errs++; $display("FAIL b2b_release in_ready got=%b want=1", w_in_ready16); end
        step();
        in_valid16 = 1'b0;
        checks++; if (w_out_valid16 !== 1'b1 || w_result16 !== 16'h0000 || w_flags16 !== 3'b100) begin errs++; $display("FAIL b2b_second valid=%b got=%h/%b want=0000/100", w_out_valid16, w_result16, w_flags16); end
        step();
        checks++; if (w_out_valid16 !== 1'b1 || w_result16 !== 16'h0003 || w_flags16 !== 3'b000) begin errs++; $display("FAIL b2b_third valid=%b got=%h/%b want=0003/000", w_out_valid16, w_result16, w_flags16); end
        step();
        checks++; if (w_out_valid16 !== 1'b0 || w_busy16 !== 1'b0) begin errs++; $display("FAIL b2b_drain valid=%b busy=%b want=0,0", w_out_valid16, w_busy16); end
    endtask

    task automatic test_reset_stall();
        int n_out;
        logic [15:0] last;
        out_ready16 = 1'b0;
        issue16(ADD, 16'h1111, 16'h0001, 4'd0);
        issue16(ADD, 16'h2222, 16'h0001, 4'd0);
        checks++; if (w_out_valid16 !== 1'b1 || w_result16 !== 16'h1112) begin errs++; $display("FAIL rst_stall_pre valid=%b res=%h want=1/1112", w_out_valid16, w_result16); end
        rst = 1'b1;
        #1;
        checks++; if (w_out_valid16 !== 1'b0 || w_result16 !== 16'h0000 || w_flags16 !== 3'b000 || w_busy16 !== 1'b0)
            begin errs++; $display("FAIL rst_stall_async valid=%b res=%h flags=%b busy=%b want=0/0000/000/0", w_out_valid16, w_result16, w_flags16, w_busy16); end
        step();
        rst = 1'b0;
        #1;
        checks++; if (w_in_ready16 !== 1'b1) begin errs++; $display("FAIL rst_stall_in_ready got=%b want=1", w_in_ready16); end
        out_ready16 = 1'b1;
        issue16(ADD, 16'h0005, 16'h0005, 4'd0);
        n_out = 0;
        last  = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (w_out_valid16 === 1'b1) begin
                n_out++;
                last = w_result16;
            end
        end
        checks++; if (n_out != 1 || last !== 16'h000A) begin errs++; $display("FAIL rst_stall_after outputs=%0d last=%h want=1/000a", n_out, last); end
    endtask

    task automatic test_shift32();
        op32 = SLL; a32 = 32'h0000_0001; b32 = '0; sh32 = 5'd31; in_valid32 = 1'b1;
        step();
        op32 = SRL; a32 = 32'h8000_0000; sh32 = 5'd31;
        step();
        op32 = SRA; a32 = 32'h8000_0000; sh32 = 5'd31;
        checks++; if (w_out_valid32 !== 1'b1 || w_result32 !== 32'h8000_0000) begin errs++; $display("FAIL sll31 valid=%b got=%h want=80000000", w_out_valid32, w_result32); end
        step();
        in_valid32 = 1'b0;
        checks++; if (w_result32 !== 32'h0000_0001) begin errs++; $display("FAIL srl31 got=%h want=00000001", w_result32); end
        step();
        checks++; if (w_result32 !== 32'hFFFF_FFFF || w_flags32 !== 3'b000) begin errs++; $display("FAIL sra31 got=%h/%b want=ffffffff/000", w_result32, w_flags32); end
        step();
    endtask

    task automatic test_random32();
        logic [31:0] q_res[$];
        logic [2:0]  q_flg[$];
        logic [31:0] corners [4];
        logic [31:0] r, exp_r;
        logic [2:0]  exp_f;
        corners[0] = 32'h0000_0000; corners[1] = 32'h7FFF_FFFF;
        corners[2] = 32'h8000_0000; corners[3] = 32'hFFFF_FFFF;
        m_flags32 = 3'b000;
        out_ready32 = 1'b1;
        for (int i = 0; i < 102; i++) begin
            if (i < 100) begin
                op32 = 3'($urandom_range(0, 7));
                a32  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
                b32  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
                sh32 = 5'($urandom_range(0, 31));
                in_valid32 = 1'b1;
                model32(op32, a32, b32, sh32, r);
                q_res.push_back(r);
                q_flg.push_back(m_flags32);
                #1;
                checks++; if (w_in_ready32 !== 1'b1) begin errs++; $display("FAIL rand_in_ready%0d got=%b want=1", i, w_in_ready32); end
            end else begin
                in_valid32 = 1'b0;
            end
            step();
            if (i >= 1 && i <= 100) begin
                if (w_out_valid32 !== 1'b1 || q_res.size() == 0) begin
                    checks++; errs++;
                    $display("FAIL rand_valid%0d got=%b want=1", i, w_out_valid32);
                end else begin
                    exp_r = q_res.pop_front();
                    exp_f = q_flg.pop_front();
                    checks++; if (w_result32 !== exp_r || w_flags32 !== exp_f)
                        begin errs++; $display("FAIL rand_op%0d got=%h/%b want=%h/%b", i, w_result32, w_flags32, exp_r, exp_f); end
                end
            end else begin
                checks++; if (w_out_valid32 !== 1'b0) begin errs++; $display("FAIL rand_idle%0d valid got=%b want=0", i, w_out_valid32); end
            end
        end
        checks++; if (q_res.size() != 0) begin errs++; $display("FAIL rand_leftover got=%0d want=0", q_res.size()); end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_saturate();
        test_flags_shift();
        test_back_to_back();
        test_reset_stall();
        test_shift32();
        test_random32();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
